pwm_demodulator: RTL and testbench

//  Receive-side counterpart of the sine PWM generator: measures an incoming PWM

---
 rtl/pwm_demodulator.sv | 108 ++++++++++
 tb/tb_pwm_demodulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demodulator.sv
// Recovers per-period high-time and period length from an asynchronous PWM input, and flags a line with no rising edge for TIMEOUT cycles.
// Latency: 3 clk edges from the first sampling of pwm_in high to meas_valid. Backpressure: none; strobes cannot be stalled.
module pwm_demodulator #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic             sync1, s, s_d;
  logic             rise, timeout_hit;
  logic             emit_meas, emit_stuck;
  logic [CNT_W-1:0] period_cnt, high_cnt, idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign rise = s & ~s_d;
  // A rise in the same cycle as the timeout is a genuine period and wins.
  assign timeout_hit = ~rise & (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    emit_meas  = 1'b0;
    emit_stuck = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (rise) begin
      emit_meas = (state == MEASURE);
      state_nxt = MEASURE;
    end else if (timeout_hit) begin
      emit_stuck = 1'b1;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      idle_cnt   <= '0;
    end else if (!enable || timeout_hit) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      idle_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= ONE;
      high_cnt   <= ONE;
      idle_cnt   <= '0;
    end else begin
      period_cnt <= period_cnt + ONE;
      high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, s};
      idle_cnt   <= idle_cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width       <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= emit_meas | emit_stuck;
      if (emit_meas) begin
        width  <= high_cnt;
        period <= period_cnt;
        stuck  <= 1'b0;
      end else if (emit_stuck) begin
        width       <= s ? TO_VAL : '0;
        period      <= TO_VAL;
        stuck       <= 1'b1;
        stuck_level <= s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed and randomized bench for pwm_demodulator; expected strobes come from a waveform-level model of rising edges and high-time.
`timescale 1ns/1ps
module tb_pwm_demodulator;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4000;

  logic             clk = 1'b0;
  logic             rst_n, enable, pwm_in;
  logic [CNT_W-1:0] width, period;
  logic             meas_valid, stuck, stuck_level;

  pwm_demodulator #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_in(pwm_in),
    .width(width), .period(period), .meas_valid(meas_valid),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  always #2.5 clk = ~clk;

  typedef struct {
    int cyc;
    int w;
    int p;
    bit st;
    bit lv;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Model state: waveform-level view of rising edges, high-time and silence.
  bit  m_en, m_prev;
  int  m_last, m_ref, m_high;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (meas_valid === 1'b1)
      got_q.push_back('{cyc, int'(width), int'(period), stuck, stuck_level});

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drives one cycle of pwm_in and predicts the strobe it causes 3 edges later.
  task automatic drive(input bit v);
    int t;
    pwm_in = v;
    if (m_en) begin
      t = cyc;
      if (v && !m_prev) begin
        if (m_last >= 0) exp_q.push_back('{t + 3, m_high, t - m_last, 1'b0, 1'b0});
        m_last = t;
        m_ref  = t;
        m_high = 0;
      end else if (t - m_ref == TIMEOUT) begin
        exp_q.push_back('{t + 3, v ? TIMEOUT : 0, TIMEOUT, 1'b1, v});
        m_ref  = t;
        m_last = -1;
      end
      m_high += int'(v);
    end
    m_prev = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pwm_period(input int h, input int p);
    for (int i = 0; i < p; i++) drive(i < h);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic compare(input string tag);
    int n;
    hold(m_prev, 4);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_%0d_cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_%0d_width", tag, i), got_q[i].w, exp_q[i].w);
      check($sformatf("%s_%0d_period", tag, i), got_q[i].p, exp_q[i].p);
      check($sformatf("%s_%0d_stuck", tag, i), got_q[i].st, exp_q[i].st);
      if (exp_q[i].st)
        check($sformatf("%s_%0d_level", tag, i), got_q[i].lv, exp_q[i].lv);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Asserts reset asynchronously, checks the outputs clear at once, then releases.
  task automatic do_reset(input string tag);
    pwm_in = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    m_en   = 1'b0;
    #1;
    check({tag, "_width"}, width, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_stuck"}, stuck, 0);
    check({tag, "_level"}, stuck_level, 0);
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    rst_n  = 1'b1;
    m_en   = 1'b1;
    m_ref  = cyc - 3;
    m_last = -1;
    m_prev = 1'b0;
    m_high = 0;
  endtask

  int sine_w[8] = '{500, 853, 999, 853, 500, 147, 1, 147};

  initial begin
    int p, h;
    rst_n  = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    m_en   = 1'b0;
    m_prev = 1'b0;
    m_last = -1;
    m_ref  = 0;
    m_high = 0;
    @(posedge clk);
    #1;

    // Steady PWM, 5 periods -> 4 strobes
    do_reset("rst0");
    for (int k = 0; k < 5; k++) pwm_period(250, 1000);
    compare("steady");

    // Sine-modulated widths
    do_reset("rst1");
    for (int k = 0; k < 8; k++) pwm_period(sine_w[k], 1000);
    compare("sine");

    // Static line low, then static high
    do_reset("rst2");
    hold(1'b0, 2 * TIMEOUT + 10);
    compare("stuck_lo");
    do_reset("rst3");
    hold(1'b1, 2 * TIMEOUT + 10);
    compare("stuck_hi");

    // Extreme duty cycles
    do_reset("rst4");
    for (int k = 0; k < 3; k++) pwm_period(1, 1000);
    for (int k = 0; k < 3; k++) pwm_period(999, 1000);
    pwm_period(1, 5);
    compare("extremes");

    // Enable dropped mid-period, outputs must hold
    do_reset("rst5");
    for (int k = 0; k < 4; k++) pwm_period(300, 1000);
    pwm_period(300, 500);
    enable = 1'b0;
    m_en   = 1'b0;
    hold(1'b0, 700);
    check("dis_width", width, 300);
    check("dis_period", period, 1000);
    check("dis_stuck", stuck, 0);
    check("dis_valid", meas_valid, 0);
    enable = 1'b1;
    m_en   = 1'b1;
    m_ref  = cyc - 3;
    m_last = -1;
    for (int k = 0; k < 3; k++) pwm_period(300, 1000);
    compare("enable");

    // Reset mid-period, then periods exactly TIMEOUT long
    do_reset("rst6");
    for (int k = 0; k < 2; k++) pwm_period(400, 1000);
    pwm_period(400, 500);
    compare("pre_rst");
    do_reset("midrst");
    for (int k = 0; k < 3; k++) pwm_period(600, 1000);
    compare("post_rst");
    for (int k = 0; k < 2; k++) pwm_period(100, TIMEOUT);
    pwm_period(5, 10);
    compare("coincident");

    // Random periods and widths, including 0% and 100% duty
    do_reset("rst7");
    for (int k = 0; k < 10; k++) begin
      p = $urandom_range(1500, 20);
      h = $urandom_range(p, 0);
      pwm_period(h, p);
    end
    pwm_period(3, 8);
    compare("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
